// File: rtl/relu_ser_pkg.sv
// Shared sizes, element/frame types and FSM state encoding for the
// ReLU output-side vector serializer.
package relu_ser_pkg;

  localparam int N_ELEM = 64;
  localparam int DATA_W = 16;
  localparam int IDX_W  = $clog2(N_ELEM);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  typedef logic signed [DATA_W-1:0] elem_t;
  typedef elem_t [0:N_ELEM-1]        frame_t;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_t;

endpackage

// File: rtl/relu_frame_reg.sv
// N_ELEM x DATA_W frame register with load enable and async active-low clear.
module relu_frame_reg
  import relu_ser_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load,
  input  logic [0:N_ELEM-1][DATA_W-1:0]    d,
  output logic [0:N_ELEM-1][DATA_W-1:0]    q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/relu_vec_serializer.sv
// Parallel frame in, one registered element per cycle out (valid/ready).
// Define SERIALIZER_PREFETCH_EN to add a shadow frame for bubble-free frames.
module relu_vec_serializer
  import relu_ser_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid_in,
  input  logic [0:N_ELEM-1][DATA_W-1:0]  input_data,
  output logic                           ready_out,
  output logic signed [DATA_W-1:0]       data_out,
  output logic [IDX_W-1:0]               index_out,
  output logic                           last_out,
  output logic                           valid_out,
  input  logic                           ready_in,
  output logic                           overrun
);

  ser_state_t       state, state_n;
  logic [IDX_W-1:0] idx_n;
  elem_t            data_n;
  logic             last_n, valid_n, ready_n, overrun_n;
  logic             take, last_beat, start, done, act_load;
  frame_t           act_src, act_q;

  relu_frame_reg u_active (
    .clk   (clk),
    .rst_n (reset),
    .load  (act_load),
    .d     (act_src),
    .q     (act_q)
  );

`ifdef SERIALIZER_PREFETCH_EN
  logic   shd_full, shd_full_n, shd_load;
  frame_t shd_q;

  relu_frame_reg u_shadow (
    .clk   (clk),
    .rst_n (reset),
    .load  (shd_load),
    .d     (input_data),
    .q     (shd_q)
  );
`endif

  always_comb begin
    state_n   = state;
    idx_n     = index_out;
    data_n    = data_out;
    last_n    = last_out;
    valid_n   = valid_out;
    overrun_n = overrun | (valid_in & ~ready_out);
    act_src   = input_data;
    take      = valid_in & ready_out;
    last_beat = (state == SEND) & ready_in & (index_out == LAST_IDX);
    start     = 1'b0;
    done      = 1'b0;
`ifdef SERIALIZER_PREFETCH_EN
    shd_load   = 1'b0;
    shd_full_n = shd_full;
`endif

    unique case (state)
      IDLE: start = take;
      SEND: begin
        if (last_beat) begin
`ifdef SERIALIZER_PREFETCH_EN
          if (shd_full) begin
            start      = 1'b1;
            act_src    = shd_q;
            shd_full_n = 1'b0;
          end else if (take) begin
            start = 1'b1;
          end else begin
            done = 1'b1;
          end
`else
          done = 1'b1;
`endif
        end else if (ready_in) begin
          idx_n  = index_out + 1'b1;
          data_n = act_q[index_out + 1'b1];
          last_n = ((index_out + 1'b1) == LAST_IDX);
        end
      end
    endcase

`ifdef SERIALIZER_PREFETCH_EN
    // In SEND, take implies the shadow is empty; on the last beat the frame goes straight to active.
    if ((state == SEND) && take && !last_beat) begin
      shd_load   = 1'b1;
      shd_full_n = 1'b1;
    end
`endif

    act_load = start;
    if (start) begin
      state_n = SEND;
      idx_n   = '0;
      data_n  = act_src[0];
      last_n  = (LAST_IDX == '0);
      valid_n = 1'b1;
    end else if (done) begin
      state_n = IDLE;
      idx_n   = '0;
      data_n  = '0;
      last_n  = 1'b0;
      valid_n = 1'b0;
    end

`ifdef SERIALIZER_PREFETCH_EN
    ready_n = (state_n == IDLE) | ~shd_full_n;
`else
    ready_n = (state_n == IDLE);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      index_out <= '0;
      data_out  <= '0;
      last_out  <= 1'b0;
      valid_out <= 1'b0;
      ready_out <= 1'b1;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      index_out <= idx_n;
      data_out  <= data_n;
      last_out  <= last_n;
      valid_out <= valid_n;
      ready_out <= ready_n;
      overrun   <= overrun_n;
    end
  end

`ifdef SERIALIZER_PREFETCH_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shd_full <= 1'b0;
    end else begin
      shd_full <= shd_full_n;
    end
  end
`endif

endmodule

// File: doc/relu_vec_serializer.md
# relu_vec_serializer

Frame-to-stream converter on the output side of the ReLU activation stage. It accepts one complete vector of signed activations, delivered in parallel with a single-cycle handshake, and replays it downstream one element per cycle under valid/ready flow control. It is the reader for the ReLU stage's parallel output, and feeds the next serial layer (dense/conv accumulator) in the CO-extraction pipeline.

## Interface
Parameters:
- N_ELEM, 64, elements per frame
- DATA_W, 16, signed element width

Ports:
- clk  input  1  rising-edge clock, the block's only clock
- reset  input  1  asynchronous, active-low reset; reset asserted when 0
- valid_in  input  1  upstream frame valid; frame transfers on the edge where valid_in && ready_out
- input_data  input  N_ELEM x DATA_W signed, [0:N_ELEM-1]  parallel frame from the ReLU stage
- ready_out  output  1  block can capture a frame this cycle
- data_out  output  DATA_W signed  current element
- index_out  output  $clog2(N_ELEM)  index of data_out within its frame
- last_out  output  1  data_out is element N_ELEM-1
- valid_out  output  1  data_out/index_out/last_out are valid
- ready_in  input  1  downstream accepts the beat; a beat transfers on valid_out && ready_in
- overrun  output  1  sticky: valid_in was seen while ready_out=0

## Operation
- The block has two states:
  - IDLE: ready_out=1 and valid_out=0. On valid_in it latches all of input_data into the active buffer, sets idx=0 and moves to SEND.
  - SEND: valid_out=1, data_out=buf[idx], index_out=idx, last_out=(idx==N_ELEM-1).
- A beat is accepted when ready_in=1. On accept, idx increments.
- When the last beat is accepted, the block returns to IDLE. The exception is the prefetch case (see Configuration).
- While ready_in=0, all outputs hold stable. Valid never drops without an accept.
- Elements pass through unmodified: no saturation, no sign change, no reordering.
- A frame is not acknowledged unless valid_in && ready_out. If valid_in=1 while ready_out=0, the frame is ignored and overrun is set. Overrun clears only on reset.
- Reset mid-frame discards the frame immediately. The block returns to IDLE.

## Timing
- Reset values: ready_out=1, valid_out=0, data_out=0, index_out=0, last_out=0, overrun=0. State is IDLE and idx=0.
- All outputs are registered. No combinational path runs from ready_in or valid_in to any output.
- Latency: frame captured at edge E, element 0 is on data_out with valid_out=1 in the cycle after E.
- Throughput: with ready_in held at 1, the block moves one element per cycle. A frame takes N_ELEM cycles in SEND.
- ready_out falls in the cycle after capture. In the non-prefetch build it rises in the cycle after the last-beat accept.
- Non-prefetch back-to-back frames: the last beat is accepted at L, capture happens at L+1 at the earliest, and element 0 appears after L+1. That gives exactly one bubble cycle of valid_out=0.
- idx never wraps while in SEND. The last-beat accept forces idx back to 0.

## Configuration
- Macro SERIALIZER_PREFETCH_EN.
- When defined, a shadow buffer is added.
  - ready_out = !shadow_full in SEND, and 1 in IDLE. A frame offered during SEND is captured into the shadow buffer.
  - On the last-beat accept with the shadow full, the shadow moves to the active buffer and idx=0. valid_out stays 1 with no bubble.
  - If the last-beat accept and valid_in coincide with the shadow empty, the new frame loads directly into the active buffer. This also gives no bubble.
  - The shadow can never be overwritten. overrun fires only when both buffers are full.
- When not defined, the single-buffer behaviour above applies and the shadow logic is absent.

## Structure
- Package relu_ser_pkg holds:
  - N_ELEM, DATA_W and IDX_W=$clog2(N_ELEM)
  - typedef elem_t (logic signed [DATA_W-1:0])
  - typedef frame_t (elem_t [0:N_ELEM-1])
  - enum ser_state_t {IDLE, SEND}
- Sub-module relu_frame_reg: an N_ELEM x DATA_W register with load enable and async active-low clear. It is instantiated once, or twice under SERIALIZER_PREFETCH_EN.

## Test plan
- Reset checks:
  - Assert reset=0 mid-SEND at idx=20 → next cycle valid_out=0, ready_out=1, index_out=0, overrun=0.
  - Then offer a frame with input_data[k]=k → element 0 appears with value 0.
- Single frame: capture ReLU-style frame [0,3540,0,0,...,0] (element 63=0) with ready_in=1 → 64 consecutive beats. Beat 1 shows data_out=3540 and index_out=1. last_out=1 only on index 63. valid_out=0 on the next cycle.
- Backpressure: toggle ready_in 1,0,0,1 repeatedly → data_out and index_out hold across stall cycles. All 64 values arrive in order, with no duplicates or drops.
- Overrun: pulse valid_in at idx=10 in the non-prefetch build → the frame is ignored, overrun=1 and stays 1. The current frame completes unchanged.
- Back-to-back frames, valid_in held 1, ready_in=1:
  - Non-prefetch: exactly one valid_out=0 cycle between beat 63 and the new beat 0.
  - SERIALIZER_PREFETCH_EN: zero gap, and the second frame's element 0 (value 7564) follows the first frame's beat 63 directly.
- Prefetch full: with the shadow full and the active frame stalled, pulse valid_in → ready_out=0 and overrun=1. The shadow contents are preserved and emitted next.
